// File: rtl/carp_pkg.sv
// Shared types and constants for the CARP core front end.
package carp_pkg;

    localparam int XLEN = 32;

    // Fetch address used after reset unless the instance overrides it.
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // RUN: no stale response expected. DROP: the outstanding response is stale.
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DROP = 1'b1
    } fetch_state_t;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Force an address onto a word boundary by clearing its two low bits.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched instructions. Entry head_r is always the oldest
// word, so the head output comes straight from a register.
module fetch_queue
    import carp_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head,
    output logic         head_valid,
    output logic [1:0]   occ
);

    fetch_entry_t head_r;
    fetch_entry_t tail_r;
    logic [1:0]   occ_r;
    logic         valid_r;

    fetch_entry_t head_next_s;
    fetch_entry_t tail_next_s;
    logic [1:0]   occ_next_s;

    // Next-state of the shift-style FIFO; flush wins over push and pop.
    always_comb begin
        head_next_s = head_r;
        tail_next_s = tail_r;
        occ_next_s  = occ_r;
        if (flush) begin
            occ_next_s = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        head_next_s = push_entry;
                        occ_next_s  = 2'd1;
                    end else if (occ_r == 2'd1) begin
                        tail_next_s = push_entry;
                        occ_next_s  = 2'd2;
                    end else begin
                        // Full: the issue gating never lets a response land here.
                        occ_next_s = occ_r;
                    end
                end
                2'b01: begin
                    if (occ_r == 2'd2) begin
                        head_next_s = tail_r;
                        occ_next_s  = 2'd1;
                    end else if (occ_r == 2'd1) begin
                        occ_next_s = 2'd0;
                    end else begin
                        occ_next_s = occ_r;
                    end
                end
                2'b11: begin
                    if (occ_r == 2'd2) begin
                        head_next_s = tail_r;
                        tail_next_s = push_entry;
                        occ_next_s  = 2'd2;
                    end else begin
                        head_next_s = push_entry;
                        occ_next_s  = 2'd1;
                    end
                end
                default: begin
                    occ_next_s = occ_r;
                end
            endcase
        end
    end

    // Storage and registered valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            occ_r   <= 2'd0;
            valid_r <= 1'b0;
        end else begin
            head_r  <= head_next_s;
            tail_r  <= tail_next_s;
            occ_r   <= occ_next_s;
            valid_r <= (occ_next_s != 2'd0);
        end
    end

    assign head       = head_r;
    assign head_valid = valid_r;
    assign occ        = occ_r;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: program counter, single-outstanding memory request
// tracking, redirect/squash handling and the 2-entry instruction queue.
module instr_fetch
    import carp_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
)
(
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            ir_valid,
    input  logic            ir_ready,
    output logic [XLEN-1:0] ir,
    output logic [XLEN-1:0] ir_pc
);

    fetch_state_t    state_r;
    logic            pending_r;
    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] req_pc_r;

    logic            drop_s;
    logic            pop_s;
    logic            push_s;
    logic [1:0]      occ_s;
    logic [2:0]      occ_next_s;
    logic            issue_s;
    logic [XLEN-1:0] addr_s;
    fetch_entry_t    push_entry_s;
    fetch_entry_t    head_s;

    // Handshake, queue occupancy look-ahead and issue decision.
    always_comb begin
        drop_s     = (state_r == ST_DROP);
        pop_s      = ir_valid & ir_ready & ~redirect;
        push_s     = imem_valid & ~drop_s & ~redirect;
        occ_next_s = {1'b0, occ_s} + {2'b00, push_s} - {2'b00, pop_s};
        if (redirect) begin
            addr_s = align_word(redirect_pc);
        end else begin
            addr_s = fetch_pc_r;
        end
        // A redirect empties the queue, so it bypasses the space check.
        issue_s = ~rst & (~pending_r | imem_valid) & (redirect | (occ_next_s < 3'd2));
        push_entry_s.pc    = req_pc_r;
        push_entry_s.instr = imem_rdata;
    end

    // PC, outstanding-request tracking and the RUN/DROP state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RUN;
            pending_r  <= 1'b0;
            fetch_pc_r <= RESET_PC;
            req_pc_r   <= '0;
        end else begin
            if (issue_s) begin
                fetch_pc_r <= addr_s + 32'd4;
                req_pc_r   <= addr_s;
                pending_r  <= 1'b1;
            end else begin
                // A deferred redirect target is parked in fetch_pc until the stale reply returns.
                if (redirect) begin
                    fetch_pc_r <= align_word(redirect_pc);
                end else begin
                    fetch_pc_r <= fetch_pc_r;
                end
                if (imem_valid) begin
                    pending_r <= 1'b0;
                end else begin
                    pending_r <= pending_r;
                end
            end
            case (state_r)
                ST_RUN: begin
                    if (redirect & pending_r & ~imem_valid) begin
                        state_r <= ST_DROP;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DROP: begin
                    if (imem_valid) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_DROP;
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
        end
    end

    fetch_queue u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .pop        (pop_s),
        .flush      (redirect),
        .push_entry (push_entry_s),
        .head       (head_s),
        .head_valid (ir_valid),
        .occ        (occ_s)
    );

    assign imem_req  = issue_s;
    assign imem_addr = addr_s;
    assign ir        = head_s.instr;
    assign ir_pc     = head_s.pc;

endmodule
